// File: rtl/vga_timing_ctrl_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FP     = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BP     = 2'd3
    } axis_state_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CNT_W    = 10;

    function automatic int axis_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int h_total(int act, int fp, int sync, int bp);
        return axis_total(act, fp, sync, bp);
    endfunction

    function automatic int v_total(int act, int fp, int sync, int bp);
        return axis_total(act, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Video timing bundle from the raster generator to the pixel datapath.
interface vga_timing_ctrl_if #(
    parameter int CNT_W = 10
);
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;

    modport master (
        output hsync, vsync, video_on, x, y, line_start, frame_start
    );

    modport slave (
        input hsync, vsync, video_on, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_ctrl_axis_fsm.sv
// One raster axis: wrapping counter plus its ACTIVE/FP/SYNC/BP region FSM.
module vga_axis_fsm
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_advance,
    output logic [CNT_W-1:0] o_cnt,
    output axis_state_e      o_state,
    output logic             o_wrap
);
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] C_FP   = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] C_SYNC = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] C_BP   = CNT_W'(ACTIVE + FP + SYNC);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TOTAL - 1);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 ||
        TOTAL > (1 << CNT_W)) begin : g_bad_params
        $error("vga_axis_fsm: illegal timing parameters");
    end

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    axis_state_e      r_state;
    axis_state_e      w_state_nxt;
    logic             w_last;

    assign w_last = (r_cnt == C_LAST);

    // State moves on the same edge the counter enters a new region.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        if (i_advance) begin
            w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
            unique case (r_state)
                ST_ACTIVE: if (w_cnt_nxt == C_FP)   w_state_nxt = ST_FP;
                ST_FP:     if (w_cnt_nxt == C_SYNC) w_state_nxt = ST_SYNC;
                ST_SYNC:   if (w_cnt_nxt == C_BP)   w_state_nxt = ST_BP;
                ST_BP:     if (w_last)              w_state_nxt = ST_ACTIVE;
                default:                            w_state_nxt = ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_state <= ST_ACTIVE;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_state = r_state;
    assign o_wrap  = i_advance && w_last;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing master: h/v axis FSMs (stage 1) feeding registered outputs (stage 2).
// Optional pixel clock-enable input when VGA_TIMING_CTRL_PIX_CE_EN is defined.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
`ifdef VGA_TIMING_CTRL_PIX_CE_EN
    input  logic pix_ce,
`endif
    vga_timing_ctrl_if.master vid
);
    logic             w_adv;
    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    axis_state_e      w_h_state;
    axis_state_e      w_v_state;
    logic             w_h_wrap;
    logic             w_v_wrap;

`ifdef VGA_TIMING_CTRL_PIX_CE_EN
    assign w_adv = pix_ce;
`else
    assign w_adv = 1'b1;
`endif

    vga_axis_fsm #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_adv),
        .o_cnt     (w_h_cnt),
        .o_state   (w_h_state),
        .o_wrap    (w_h_wrap)
    );

    vga_axis_fsm #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_h_wrap),
        .o_cnt     (w_v_cnt),
        .o_state   (w_v_state),
        .o_wrap    (w_v_wrap)
    );

    // Origin flags track the counters, so start pulses need no wide compares.
    logic r_h_origin;
    logic r_v_origin;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_origin <= 1'b1;
            r_v_origin <= 1'b1;
        end else if (w_adv) begin
            r_h_origin <= w_h_wrap;
            r_v_origin <= w_v_wrap;
        end
    end

    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_line_start;
    logic             r_frame_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_adv) begin
            r_hsync       <= (w_h_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_v_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= (w_h_state == ST_ACTIVE) &&
                             (w_v_state == ST_ACTIVE);
            r_x           <= w_h_cnt;
            r_y           <= w_v_cnt;
            r_line_start  <= r_h_origin;
            r_frame_start <= r_h_origin && r_v_origin;
        end
    end

    assign vid.hsync       = r_hsync;
    assign vid.vsync       = r_vsync;
    assign vid.video_on    = r_video_on;
    assign vid.x           = r_x;
    assign vid.y           = r_y;
    assign vid.line_start  = r_line_start;
    assign vid.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench: default 640x480 instance plus a tiny SYNC_POL=1 instance.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef VGA_TIMING_CTRL_PIX_CE_EN
    logic pix_ce = 1'b1;
`endif

    always #5 clk = ~clk;

    vga_timing_ctrl_if #(.CNT_W(10)) vif_d ();
    vga_timing_ctrl_if #(.CNT_W(4))  vif_s ();

    vga_timing_ctrl u_def (
        .clk    (clk),
        .rst    (rst),
`ifdef VGA_TIMING_CTRL_PIX_CE_EN
        .pix_ce (pix_ce),
`endif
        .vid    (vif_d)
    );

    vga_timing_ctrl #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (2),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .SYNC_POL (1'b1),
        .CNT_W    (4)
    ) u_sm (
        .clk    (clk),
        .rst    (rst),
`ifdef VGA_TIMING_CTRL_PIX_CE_EN
        .pix_ce (pix_ce),
`endif
        .vid    (vif_s)
    );

    typedef struct {
        int    cyc;
        bit    sm;
        string nm;
        logic  hs;
        logic  vs;
        logic  von;
        int    x;
        int    y;
        logic  ls;
        logic  fs;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   cyc    = 0;

    task automatic chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    task automatic push(int c, bit sm, string nm, logic hs, logic vs,
                        logic von, int x, int y, logic ls, logic fs);
        exp_t e;
        int   i;
        e.cyc = c; e.sm = sm; e.nm = nm;
        e.hs = hs; e.vs = vs; e.von = von;
        e.x = x; e.y = y; e.ls = ls; e.fs = fs;
        i = q.size();
        while (i > 0 && q[i-1].cyc > c) i--;
        q.insert(i, e);
    endtask

    // Window statistics gathered alongside the scoreboard.
    int d_hs_low = 0, d_hs_fx = -1, d_von_n = 0, d_ls_n = 0;
    int d_ls_c1 = 0, d_ls_c2 = 0, d_xmax = 0;
    int s_vs_hi = 0, s_hs_hi = 0, s_fs_n = 0, s_xmax = 0, s_ymax = 0;

    initial begin
        exp_t e;
        logic hs, vs, von, ls, fs;
        int   x, y;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc >= 4 && cyc < 804) begin
                if (!vif_d.hsync) begin
                    if (d_hs_low == 0) d_hs_fx = int'(vif_d.x);
                    d_hs_low++;
                end
                if (vif_d.video_on) d_von_n++;
            end
            if (cyc >= 4 && cyc < 1605 && vif_d.line_start) begin
                d_ls_n++;
                if (d_ls_n == 1) d_ls_c1 = cyc;
                if (d_ls_n == 2) d_ls_c2 = cyc;
            end
            if (cyc >= 4 && cyc < 1900) begin
                if (int'(vif_d.x) > d_xmax) d_xmax = int'(vif_d.x);
                if (int'(vif_s.x) > s_xmax) s_xmax = int'(vif_s.x);
            end
            if (cyc >= 4 && cyc < 102) begin
                if (vif_s.vsync) s_vs_hi++;
                if (int'(vif_s.y) > s_ymax) s_ymax = int'(vif_s.y);
            end
            if (cyc >= 4 && cyc < 18 && vif_s.hsync) s_hs_hi++;
            if (cyc >= 4 && cyc < 201 && vif_s.frame_start) s_fs_n++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.sm) begin
                    hs = vif_s.hsync; vs = vif_s.vsync;
                    von = vif_s.video_on;
                    x = int'(vif_s.x); y = int'(vif_s.y);
                    ls = vif_s.line_start; fs = vif_s.frame_start;
                end else begin
                    hs = vif_d.hsync; vs = vif_d.vsync;
                    von = vif_d.video_on;
                    x = int'(vif_d.x); y = int'(vif_d.y);
                    ls = vif_d.line_start; fs = vif_d.frame_start;
                end
                n_tot++;
                if (e.cyc == cyc && hs === e.hs && vs === e.vs &&
                    von === e.von && x == e.x && y == e.y &&
                    ls === e.ls && fs === e.fs) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s @%0d: got hs%b vs%b von%b x%0d y%0d ls%b fs%b, want hs%b vs%b von%b x%0d y%0d ls%b fs%b",
                             e.nm, cyc, hs, vs, von, x, y, ls, fs,
                             e.hs, e.vs, e.von, e.x, e.y, e.ls, e.fs);
                end
            end
        end
    end

    initial begin
        // Reset state, then first frame; position p is presented at cycle 4+p.
        push(3, 0, "def_reset", 1, 1, 0, 0, 0, 0, 0);
        push(3, 1, "sm_reset",  0, 0, 0, 0, 0, 0, 0);
        push(4,    0, "def_p0",    1, 1, 1, 0,   0, 1, 1);
        push(5,    0, "def_p1",    1, 1, 1, 1,   0, 0, 0);
        push(643,  0, "def_x639",  1, 1, 1, 639, 0, 0, 0);
        push(644,  0, "def_x640",  1, 1, 0, 640, 0, 0, 0);
        push(659,  0, "def_x655",  1, 1, 0, 655, 0, 0, 0);
        push(660,  0, "def_x656",  0, 1, 0, 656, 0, 0, 0);
        push(755,  0, "def_x751",  0, 1, 0, 751, 0, 0, 0);
        push(756,  0, "def_x752",  1, 1, 0, 752, 0, 0, 0);
        push(803,  0, "def_x799",  1, 1, 0, 799, 0, 0, 0);
        push(804,  0, "def_line1", 1, 1, 1, 0,   1, 1, 0);
        push(1604, 0, "def_line2", 1, 1, 1, 0,   2, 1, 0);
        push(4,   1, "sm_p0",   0, 0, 1, 0,  0, 1, 1);
        push(12,  1, "sm_x8",   0, 0, 0, 8,  0, 0, 0);
        push(14,  1, "sm_x10",  1, 0, 0, 10, 0, 0, 0);
        push(15,  1, "sm_x11",  1, 0, 0, 11, 0, 0, 0);
        push(16,  1, "sm_x12",  0, 0, 0, 12, 0, 0, 0);
        push(17,  1, "sm_x13",  0, 0, 0, 13, 0, 0, 0);
        push(18,  1, "sm_line1", 0, 0, 1, 0, 1, 1, 0);
        push(60,  1, "sm_y4",   0, 0, 0, 0,  4, 1, 0);
        push(74,  1, "sm_y5",   0, 1, 0, 0,  5, 1, 0);
        push(88,  1, "sm_y6",   0, 0, 0, 0,  6, 1, 0);
        push(101, 1, "sm_last", 0, 0, 0, 13, 6, 0, 0);
        push(102, 1, "sm_frm1", 0, 0, 1, 0,  0, 1, 1);
        push(200, 1, "sm_frm2", 0, 0, 1, 0,  0, 1, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (1900) @(negedge clk);

        // Mid-line reset at default (300,2); restart presents (0,0) at 1906.
        push(1904, 0, "def_pre_rst",  1, 1, 1, 300, 2, 0, 0);
        push(1904, 1, "sm_pre_rst",   1, 0, 0, 10,  2, 0, 0);
        push(1905, 0, "def_mid_rst",  1, 1, 0, 0,   0, 0, 0);
        push(1905, 1, "sm_mid_rst",   0, 0, 0, 0,   0, 0, 0);
        push(1906, 0, "def_rst_p0",   1, 1, 1, 0,   0, 1, 1);
        push(1906, 1, "sm_rst_p0",    0, 0, 1, 0,   0, 1, 1);
        push(1907, 0, "def_rst_p1",   1, 1, 1, 1,   0, 0, 0);
        push(2004, 1, "sm_rst_frm1",  0, 0, 1, 0,   0, 1, 1);
        push(2561, 0, "def_rst_x655", 1, 1, 0, 655, 0, 0, 0);
        push(2562, 0, "def_rst_x656", 0, 1, 0, 656, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (700) @(negedge clk);

        chk("def_hs_low_len", d_hs_low, 96);
        chk("def_hs_first_x", d_hs_fx, 656);
        chk("def_von_line0",  d_von_n, 640);
        chk("def_ls_count",   d_ls_n, 3);
        chk("def_ls_period",  d_ls_c2 - d_ls_c1, 800);
        chk("def_x_max",      d_xmax, 799);
        chk("sm_vs_high_len", s_vs_hi, 14);
        chk("sm_hs_high_len", s_hs_hi, 2);
        chk("sm_fs_count",    s_fs_n, 3);
        chk("sm_x_max",       s_xmax, 13);
        chk("sm_y_max",       s_ymax, 6);
        chk("sb_drained",     q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Generates VGA raster timing: horizontal and vertical counters, sync pulses, active-video flag and pixel coordinates. It sequences the design's registered pixel pipeline stages. It sits between the pixel clock domain root and the pixel/colour datapath, and it is the single timing master for one display output.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high)
CNT_W, 10, counter/coordinate width; must satisfy 2^CNT_W >= H_TOTAL and 2^CNT_W >= V_TOTAL

Ports:
clk  input  1  pixel clock; all logic rising-edge
rst  input  1  synchronous reset, active-high
hsync  output  1  horizontal sync, level per SYNC_POL
vsync  output  1  vertical sync, level per SYNC_POL
video_on  output  1  high while (x,y) lies in the active area
x  output  CNT_W  current horizontal count
y  output  CNT_W  current vertical count
line_start  output  1  one-cycle pulse when x==0
frame_start  output  1  one-cycle pulse when x==0 and y==0

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Region order per axis: ACTIVE, FRONT_PORCH, SYNC, BACK_PORCH, then wrap to ACTIVE. Each axis has a 4-state FSM; its state changes exactly at the region boundary counts.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt advances only on the h wrap, counts 0..V_TOTAL-1 and wraps to 0. v_cnt changes on the same edge that h_cnt goes from H_TOTAL-1 to 0.
- Two-stage pipeline:
  - Counters and FSM states are stage 1.
  - All outputs are stage-2 registers decoded from the stage-1 values.
  - Counter-to-output latency is 1 cycle.
- Decode rules:
  - hsync is asserted iff h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync is asserted iff v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - x = h_cnt and y = v_cnt, unmasked in all regions.
- Reset (any clk edge with rst=1):
  - h_cnt=0, v_cnt=0, both FSMs in ACTIVE.
  - hsync=vsync=!SYNC_POL (deasserted), video_on=0, x=0, y=0, line_start=0, frame_start=0.
- First edge with rst=0: outputs present (0,0) with video_on=1, line_start=1, frame_start=1. Counters move to (1,0).
- Reset asserted mid-line or mid-frame: on that edge the block abandons the current frame. Outputs take their reset values on the same edge. There is no partial sync pulse afterwards; the next frame starts cleanly at (0,0).
- Counters never exceed TOTAL-1. No counter state is unreachable after reset.
- Parameter legality: every porch and sync width >= 1. Violations are an elaboration error.

Optional Feature:
Macro VGA_TIMING_CTRL_PIX_CE_EN.
- Defined: adds input port pix_ce (1 bit, placed after rst). Counters and FSMs advance only on edges where pix_ce=1. The stage-2 output registers also load only when pix_ce=1. line_start and frame_start are asserted for one pix_ce-qualified cycle and then held until the next pix_ce edge. This allows a system clock that is a multiple of the pixel rate. Reset overrides pix_ce.
- Not defined: no pix_ce port; the block advances every cycle.

Decomposition:
- Shared package vga_timing_pkg holds:
  - axis state enum (ST_ACTIVE, ST_FP, ST_SYNC, ST_BP, 2 bits);
  - default 640x480@60 timing constants;
  - derived H_TOTAL/V_TOTAL helper functions.
- Sub-module vga_axis_fsm: one counter plus its 4-state region FSM, with inputs advance and four length parameters, and outputs cnt, state, wrap. It is instantiated twice. The h instance has advance=1 (or pix_ce); the v instance has advance = the h instance's wrap.

Test Plan:
- Defaults; release reset -> frame_start and line_start high on the first post-reset cycle with x=0, y=0, video_on=1. line_start recurs every 800 cycles; frame_start recurs every 420000 cycles.
- Defaults; watch line 0 -> hsync low for exactly 96 cycles, first low output at x=656. video_on falls when x=640 is presented and rises when x=0 is presented.
- Defaults -> vsync low for exactly 1600 cycles (2 lines) while y=490..491. video_on=0 for every y >= 480.
- Assert rst for 1 cycle at (x=300, y=200) -> outputs reset on that edge. The next cycle presents (0,0) with frame_start=1. vsync/hsync have no glitch.
- SYNC_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> line period 14 cycles, frame period 98 cycles. hsync is high for x=10..11 and vsync is high for y=5.
- VGA_TIMING_CTRL_PIX_CE_EN defined, pix_ce pulsed 1-in-4 -> line period 3200 clk cycles. Outputs are stable between pix_ce pulses. rst during pix_ce=0 still resets.
